// File: rtl/iso14443a_pkg.sv
// Shared definitions for the ISO14443-A reader-side scheduler.
//   - datapath mod_type encodings (values the front end decodes)
//   - transaction completion status codes
//   - scheduler state encoding
package iso14443a_pkg;

    localparam logic [2:0] MODE_SNIFFER       = 3'b000;
    localparam logic [2:0] MODE_TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] MODE_TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] MODE_READER_LISTEN = 3'b011;
    localparam logic [2:0] MODE_READER_MOD    = 3'b100;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'b00,
        STATUS_TIMEOUT  = 2'b01,
        STATUS_OVERFLOW = 2'b10,
        STATUS_ABORTED  = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_WAIT = 3'd1,
        TX      = 3'd2,
        FDT     = 3'd3,
        LISTEN  = 3'd4,
        RX      = 3'd5
    } sched_state_t;

endpackage

// File: rtl/iso14443a_slot_timer.sv
// Slot counter used by the reader scheduler.
// Counts enabled strobes, clears synchronously, and sticks at all ones
// instead of wrapping.
// Ports:
//   ck_1356meg    carrier clock, state changes on the falling edge
//   rst           asynchronous active-high reset (count -> 0)
//   clr           synchronous clear, wins over en
//   en            count one slot this cycle
//   limit         value the count is compared against
//   count         current count
//   hit           the increment taken now would land exactly on limit
module iso14443a_slot_timer
    import iso14443a_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ck_1356meg,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(1);
    // Guard against count_inc wrapping to zero when the counter is saturated.
    assign hit       = (count != CNT_MAX) && (count_inc == limit);

    always_ff @(negedge ck_1356meg or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/iso14443a_reader_sched.sv
// Reader-side transaction sequencer for the ISO14443-A datapath.
// One accepted command runs: transmit (READER_MOD) -> frame delay guard ->
// listen (READER_LISTEN) -> response capture, each phase timed in 16-tick
// bit slots marked by slot_strobe. The end of the exchange is reported by a
// one-cycle done pulse with a status code and the response length.
// Ports:
//   ck_1356meg         carrier clock (falling edge active)
//   rst                asynchronous active-high reset
//   slot_strobe        one-cycle pulse per 16 carrier ticks
//   rx_bit             demodulated tag bit, valid with slot_strobe
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_tx_slots       slots to transmit
//   cmd_fdt_slots      guard slots after transmit
//   cmd_timeout_slots  listen slots before timeout (0 = never)
//   abort              cancel the running transaction
//   mod_type           datapath mode
//   tx_active          ARM should stream modulation data
//   busy               transaction in progress
//   done               completion pulse
//   status             completion code, held until next done
//   rx_slots           response length, first to last '1', held until next done
module iso14443a_reader_sched
    import iso14443a_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int SILENCE_SLOTS = 4
) (
    input  logic             ck_1356meg,
    input  logic             rst,
    input  logic             slot_strobe,
    input  logic             rx_bit,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_tx_slots,
    input  logic [CNT_W-1:0] cmd_fdt_slots,
    input  logic [CNT_W-1:0] cmd_timeout_slots,
    input  logic             abort,
    output logic [2:0]       mod_type,
    output logic             tx_active,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] rx_slots
);

    localparam int               SIL_W    = $clog2(SILENCE_SLOTS + 1);
    localparam logic [CNT_W-1:0] RX_LIMIT = '1;

    sched_state_t     state, state_n;
    logic [2:0]       mod_type_n;
    logic             tx_active_n, busy_n, done_n;
    logic [1:0]       status_n;
    logic [CNT_W-1:0] rx_slots_n;
    logic [CNT_W-1:0] last_one, last_one_n;
    logic [SIL_W-1:0] silence, silence_n, silence_inc;

    logic [CNT_W-1:0] tx_len, fdt_len, to_len;
    logic             accept;

    logic             ph_clr, ph_en, ph_hit;
    logic [CNT_W-1:0] ph_limit, ph_count;
    logic             rx_clr, rx_en, rx_hit;
    logic [CNT_W-1:0] rx_count, rx_count_inc;

    assign cmd_ready    = (state == IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign silence_inc  = silence + SIL_W'(1);
    assign rx_count_inc = rx_count + CNT_W'(1);

    // Shared phase counter for TX, FDT and LISTEN; cleared at every phase change.
    iso14443a_slot_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .clr        (ph_clr),
        .en         (ph_en),
        .limit      (ph_limit),
        .count      (ph_count),
        .hit        (ph_hit)
    );

    // Response length counter; hit flags the step onto the saturation value.
    iso14443a_slot_timer #(.CNT_W(CNT_W)) u_rx_timer (
        .ck_1356meg (ck_1356meg),
        .rst        (rst),
        .clr        (rx_clr),
        .en         (rx_en),
        .limit      (RX_LIMIT),
        .count      (rx_count),
        .hit        (rx_hit)
    );

    // Command lengths are data: captured at accept, not reset.
    always_ff @(negedge ck_1356meg) begin
        if (accept) begin
            tx_len  <= cmd_tx_slots;
            fdt_len <= cmd_fdt_slots;
            to_len  <= cmd_timeout_slots;
        end
    end

    always_ff @(negedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mod_type  <= MODE_SNIFFER;
            tx_active <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= STATUS_OK;
            rx_slots  <= '0;
            last_one  <= '0;
            silence   <= '0;
        end else begin
            state     <= state_n;
            mod_type  <= mod_type_n;
            tx_active <= tx_active_n;
            busy      <= busy_n;
            done      <= done_n;
            status    <= status_n;
            rx_slots  <= rx_slots_n;
            last_one  <= last_one_n;
            silence   <= silence_n;
        end
    end

    always_comb begin
        state_n     = state;
        mod_type_n  = mod_type;
        tx_active_n = tx_active;
        busy_n      = busy;
        done_n      = 1'b0;
        status_n    = status;
        rx_slots_n  = rx_slots;
        last_one_n  = last_one;
        silence_n   = silence;
        ph_clr      = 1'b0;
        ph_en       = 1'b0;
        ph_limit    = '0;
        rx_clr      = 1'b1;
        rx_en       = 1'b0;

        if ((state != IDLE) && abort) begin
            state_n     = IDLE;
            mod_type_n  = MODE_SNIFFER;
            tx_active_n = 1'b0;
            busy_n      = 1'b0;
            done_n      = 1'b1;
            status_n    = STATUS_ABORTED;
            rx_slots_n  = '0;
            ph_clr      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ph_clr = 1'b1;
                    if (cmd_valid) begin
                        busy_n = 1'b1;
                        if (cmd_tx_slots != '0) begin
                            state_n = TX_WAIT;
                        end else begin
                            state_n    = FDT;
                            mod_type_n = MODE_READER_LISTEN;
                        end
                    end
                end

                // Transmission is aligned to a slot boundary; the first
                // strobe both starts modulation and counts as slot 1.
                TX_WAIT: begin
                    if (slot_strobe) begin
                        ph_en       = 1'b1;
                        mod_type_n  = MODE_READER_MOD;
                        tx_active_n = 1'b1;
                        state_n     = TX;
                    end
                end

                TX: begin
                    if (slot_strobe) begin
                        if (ph_count == tx_len) begin
                            ph_clr      = 1'b1;
                            mod_type_n  = MODE_READER_LISTEN;
                            tx_active_n = 1'b0;
                            state_n     = FDT;
                        end else begin
                            ph_en = 1'b1;
                        end
                    end
                end

                FDT: begin
                    ph_limit = fdt_len;
                    if (fdt_len == '0) begin
                        ph_clr  = 1'b1;
                        state_n = LISTEN;
                    end else if (slot_strobe) begin
                        if (ph_hit) begin
                            ph_clr  = 1'b1;
                            state_n = LISTEN;
                        end else begin
                            ph_en = 1'b1;
                        end
                    end
                end

                // A '1' on the expiry strobe is checked first, so a late
                // response still wins over the timeout.
                LISTEN: begin
                    ph_limit = to_len;
                    if (slot_strobe) begin
                        if (rx_bit) begin
                            ph_clr     = 1'b1;
                            rx_clr     = 1'b0;
                            rx_en      = 1'b1;
                            last_one_n = CNT_W'(1);
                            silence_n  = '0;
                            state_n    = RX;
                        end else if ((to_len != '0) && ph_hit) begin
                            ph_clr      = 1'b1;
                            state_n     = IDLE;
                            mod_type_n  = MODE_SNIFFER;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                            status_n    = STATUS_TIMEOUT;
                            rx_slots_n  = '0;
                        end else begin
                            ph_en = 1'b1;
                        end
                    end
                end

                // Silence reached on the same strobe as saturation is
                // reported as a normal end of response.
                RX: begin
                    rx_clr = 1'b0;
                    if (slot_strobe) begin
                        rx_en = 1'b1;
                        if (rx_bit) begin
                            last_one_n = rx_count_inc;
                            silence_n  = '0;
                        end else begin
                            silence_n = silence_inc;
                        end
                        if (!rx_bit && (silence_inc == SIL_W'(SILENCE_SLOTS))) begin
                            state_n     = IDLE;
                            mod_type_n  = MODE_SNIFFER;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                            status_n    = STATUS_OK;
                            rx_slots_n  = last_one;
                        end else if (rx_hit) begin
                            state_n     = IDLE;
                            mod_type_n  = MODE_SNIFFER;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                            status_n    = STATUS_OVERFLOW;
                            rx_slots_n  = '1;
                        end
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iso14443a_reader_sched.sv
// Bench for iso14443a_reader_sched: a 16-bit instance and a 4-bit instance
// share the stimulus; sel4 picks which one is checked. Expected results come
// from a transaction-level model that derives slot indices from the command
// lengths and the rx bit pattern.
module tb_iso14443a_reader_sched;

    localparam int NRX = 256;
    localparam int SIL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slot_strobe = 1'b0;
    logic        rx_bit = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cmd_tx = '0, cmd_fdt = '0, cmd_to = '0;
    bit          sel4 = 1'b0;

    logic        rdy16, txa16, busy16, done16;
    logic [2:0]  mod16;
    logic [1:0]  st16;
    logic [15:0] rxs16;
    logic        rdy4, txa4, busy4, done4;
    logic [2:0]  mod4;
    logic [1:0]  st4;
    logic [3:0]  rxs4;

    logic        rdy, txa, busy, done;
    logic [2:0]  mod;
    logic [1:0]  st;
    logic [15:0] rxs;

    assign rdy  = sel4 ? rdy4  : rdy16;
    assign txa  = sel4 ? txa4  : txa16;
    assign busy = sel4 ? busy4 : busy16;
    assign done = sel4 ? done4 : done16;
    assign mod  = sel4 ? mod4  : mod16;
    assign st   = sel4 ? st4   : st16;
    assign rxs  = sel4 ? 16'(rxs4) : rxs16;

    always #5 clk = ~clk;

    iso14443a_reader_sched #(.CNT_W(16), .SILENCE_SLOTS(SIL)) dut (
        .ck_1356meg        (clk),
        .rst               (rst),
        .slot_strobe       (slot_strobe),
        .rx_bit            (rx_bit),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (rdy16),
        .cmd_tx_slots      (cmd_tx),
        .cmd_fdt_slots     (cmd_fdt),
        .cmd_timeout_slots (cmd_to),
        .abort             (abort),
        .mod_type          (mod16),
        .tx_active         (txa16),
        .busy              (busy16),
        .done              (done16),
        .status            (st16),
        .rx_slots          (rxs16)
    );

    iso14443a_reader_sched #(.CNT_W(4), .SILENCE_SLOTS(SIL)) dut4 (
        .ck_1356meg        (clk),
        .rst               (rst),
        .slot_strobe       (slot_strobe),
        .rx_bit            (rx_bit),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (rdy4),
        .cmd_tx_slots      (cmd_tx[3:0]),
        .cmd_fdt_slots     (cmd_fdt[3:0]),
        .cmd_timeout_slots (cmd_to[3:0]),
        .abort             (abort),
        .mod_type          (mod4),
        .tx_active         (txa4),
        .busy              (busy4),
        .done              (done4),
        .status            (st4),
        .rx_slots          (rxs4)
    );

    int errors = 0;
    int checks = 0;
    bit rxv [0:NRX-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_rx();
        for (int i = 0; i < NRX; i++) rxv[i] = 1'b0;
    endtask

    // Index of the last strobe before listening starts (strobes counted from 1 after accept).
    function automatic int listen_base(input int tx, input int fdt);
        return (tx > 0 ? 1 + tx : 0) + fdt;
    endfunction

    // Mode seen just before strobe k.
    function automatic logic [2:0] exp_mode(input int tx, input int k);
        if (tx == 0)      return 3'b011;
        if (k == 1)       return 3'b000;
        if (k <= tx + 1)  return 3'b100;
        return 3'b011;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mod"},  mod,  0);
        chk({tag, "_txa"},  txa,  0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_st"},   st,   0);
        chk({tag, "_rxs"},  rxs,  0);
        chk({tag, "_rdy"},  rdy,  1);
    endtask

    task automatic run_txn(input int tx, input int fdt, input int to,
                           input int abort_k, input int rst_k, input bit abt_acc);
        int b, r, end_k, exp_st, exp_len, maxc, last1, zrun, ok_k, ov_k;
        int gap, k, done_k, budget;
        bit rst_exp, rst_hit;
        maxc = sel4 ? 15 : 65535;
        b = listen_base(tx, fdt);
        r = 0; end_k = 0; exp_st = 0; exp_len = 0;
        for (int j = 1; b + j < NRX; j++) begin
            if (rxv[b + j]) begin r = b + j; break; end
            if (to != 0 && j == to) begin end_k = b + j; exp_st = 1; break; end
        end
        if (r != 0) begin
            last1 = r; zrun = 0; ok_k = 0;
            for (int kk = r + 1; kk < NRX; kk++) begin
                if (rxv[kk]) begin last1 = kk; zrun = 0; end
                else zrun++;
                if (zrun == SIL) begin ok_k = kk; break; end
            end
            ov_k = r + maxc - 1;
            if (ok_k != 0 && ok_k <= ov_k) begin
                end_k = ok_k; exp_st = 0; exp_len = last1 - r + 1;
            end else begin
                end_k = ov_k; exp_st = 2; exp_len = maxc;
            end
        end
        rst_exp = (rst_k > 0 && rst_k < end_k);
        if (abort_k > 0 && abort_k < end_k) begin
            end_k = abort_k; exp_st = 3; exp_len = 0;
        end
        if (end_k == 0) begin
            chk("model_end", 0, 1);
            return;
        end

        cmd_tx = 16'(tx); cmd_fdt = 16'(fdt); cmd_to = 16'(to);
        cmd_valid = 1'b1; abort = abt_acc;
        @(posedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_rdy",  rdy,  0);
        chk("acc_done", done, 0);
        chk("acc_mod",  mod,  (tx == 0) ? 3 : 0);

        gap = $urandom_range(3, 12);
        k = 0; done_k = -1; rst_hit = 1'b0;
        budget = gap + 16 * (end_k + 2);
        for (int c = 0; c < budget; c++) begin
            if (c >= gap && (c - gap) % 16 == 0) begin
                k++;
                if (k <= end_k) begin
                    chk("mod_slot", mod, exp_mode(tx, k));
                    chk("txa_slot", txa, exp_mode(tx, k) == 3'b100);
                end
                slot_strobe = 1'b1;
                rx_bit = (k < NRX) ? rxv[k] : 1'b0;
            end else begin
                slot_strobe = 1'b0;
                rx_bit = 1'($urandom);
            end
            abort = (abort_k > 0 && k == abort_k && c >= gap && (c - gap) % 16 == 5);
            if (rst_exp && k == rst_k && c >= gap && (c - gap) % 16 == 5) begin
                #2 rst = 1'b1;
                #1 chk_reset_vals("rst_async");
                rst_hit = 1'b1;
                break;
            end
            @(posedge clk);
            if (done) begin done_k = k; break; end
        end
        slot_strobe = 1'b0; abort = 1'b0;

        if (rst_exp) begin
            chk("rst_hit", rst_hit, 1);
            @(posedge clk);
            rst = 1'b0;
            repeat (4) begin
                @(posedge clk);
                chk("rst_nodone", done, 0);
            end
            chk("rst_rdy", rdy, 1);
        end else begin
            chk("end_slot", done_k, end_k);
            chk("end_st",   st,   exp_st);
            chk("end_rxs",  rxs,  exp_len);
            chk("end_mod",  mod,  0);
            chk("end_txa",  txa,  0);
            chk("end_busy", busy, 0);
            chk("end_rdy",  rdy,  1);
            @(posedge clk);
            chk("done_pulse", done, 0);
            chk("st_hold",    st,   exp_st);
        end
    endtask

    task automatic rand_txn(input int txmax, input int fdtmax, input int tomax);
        int tx, fdt, to, b, ab, dens;
        tx  = $urandom_range(0, txmax);
        fdt = $urandom_range(0, fdtmax);
        to  = $urandom_range(1, tomax);
        if ($urandom_range(0, 7) == 0) to = 0;
        clear_rx();
        b = listen_base(tx, fdt);
        dens = $urandom_range(1, 3);
        for (int i = b + 1; i <= b + tomax + 20 && i < NRX; i++)
            rxv[i] = ($urandom_range(0, 3) < dens);
        if (to == 0) rxv[b + $urandom_range(1, tomax)] = 1'b1;
        ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, b + 10) : 0;
        run_txn(tx, fdt, to, ab, 0, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int b;
        repeat (3) @(posedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        @(posedge clk);

        // abort while idle does nothing
        abort = 1'b1;
        @(posedge clk);
        abort = 1'b0;
        chk("idle_abort_done", done, 0);
        chk("idle_abort_rdy",  rdy,  1);

        // response at listen slots 2,3,5
        clear_rx();
        b = listen_base(8, 3);
        rxv[b + 2] = 1'b1; rxv[b + 3] = 1'b1; rxv[b + 5] = 1'b1;
        run_txn(8, 3, 20, 0, 0, 1'b0);
        chk("tp1_st", st, 0);
        chk("tp1_rxs", rxs, 4);

        // silent tag -> timeout on 5th listen strobe
        clear_rx();
        run_txn(4, 2, 5, 0, 0, 1'b0);
        chk("tp2_st", st, 1);

        // no transmit, no guard
        clear_rx();
        b = listen_base(0, 0);
        rxv[b + 4] = 1'b1; rxv[b + 5] = 1'b1;
        run_txn(0, 0, 10, 0, 0, 1'b0);

        // abort during transmit slot 3
        clear_rx();
        run_txn(8, 3, 20, 3, 0, 1'b0);
        chk("tp4_st", st, 3);

        // reset in the middle of a response
        clear_rx();
        b = listen_base(2, 1);
        for (int i = 1; i <= 6; i++) rxv[b + i] = 1'b1;
        run_txn(2, 1, 10, 0, b + 3, 1'b0);

        // timeout disabled, late response; abort together with the command
        clear_rx();
        b = listen_base(3, 2);
        rxv[b + 25] = 1'b1;
        run_txn(3, 2, 0, 0, 0, 1'b1);
        chk("tp6_st", st, 0);

        for (int n = 0; n < 24; n++) rand_txn(12, 6, 30);

        // 4-bit instance
        sel4 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        chk_reset_vals("w4_rst");

        clear_rx();
        b = listen_base(2, 1);
        for (int i = 1; i <= 40; i++) rxv[b + i] = 1'b1;
        run_txn(2, 1, 10, 0, 0, 1'b0);
        chk("ov_st", st, 2);
        chk("ov_rxs", rxs, 15);

        clear_rx();
        b = listen_base(1, 2);
        rxv[b + 6] = 1'b1;
        run_txn(1, 2, 6, 0, 0, 1'b0);
        chk("exp_st", st, 0);
        chk("exp_rxs", rxs, 1);

        for (int n = 0; n < 8; n++) rand_txn(5, 3, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
